// File: rtl/permute_slice_worker.sv
// permute_slice_worker: streams SLICES 25-bit slices through pi (inverse pi with PERMUTE_INVERSE_EN) and writes them back in place
module permute_slice_worker #(
  parameter int SLICES = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [24:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [24:0]       mem_wr_data,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SLICES - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wr_addr_q;
  logic wr_en_q;
  logic [24:0] pi;
  for (genvar x = 0; x < 5; x++) begin : g_x
    for (genvar y = 0; y < 5; y++) begin : g_y
`ifdef PERMUTE_INVERSE_EN
      assign pi[x + 5*y] = mem_rd_data[y + 5*((2*x + 3*y) % 5)];
`else
      assign pi[x + 5*y] = mem_rd_data[(x + 3*y) % 5 + 5*x];
`endif
    end
  end
  // state, read counter and the one-stage write-address pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= state_q == RUN;
      wr_addr_q <= cnt_q;
    end
  end
  // next state: launch from IDLE only, count reads up to the last slice, then drain one write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = start ? RUN : IDLE;
        cnt_d   = start ? '0 : cnt_q;
      end
      RUN: begin
        state_d = cnt_q == LAST_ADDR ? LAST : RUN;
        cnt_d   = cnt_q == LAST_ADDR ? cnt_q : cnt_q + 1'b1;
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign done        = state_q == IDLE;
  assign mem_rd_en   = state_q == RUN;
  assign mem_rd_addr = mem_rd_en ? cnt_q : '0;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_en_q ? wr_addr_q : '0;
  assign mem_wr_data = wr_en_q ? pi : '0;
endmodule

// File: doc/permute_slice_worker.md
# permute_slice_worker

Per-instance responder for the permute stage of the encoder. It is launched by the permute top-level controller's one-cycle start pulse. It streams `SLICES` 25-bit state slices out of its slice memory, applies the Keccak ρ-free π lane permutation to each slice, and writes the result back in place. Its `done` output feeds the AND-tree that forms the top controller's `all_done`.

## Interface
Parameters:
- `SLICES`, 64: number of slices processed per run.
- `ADDR_W`, 6: slice address width; `SLICES` ≤ 2^`ADDR_W`.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start`  in  1: one-cycle launch pulse from the top controller's `start_instances`.
- `mem_rd_en`  out  1: slice memory read strobe.
- `mem_rd_addr`  out  `ADDR_W`: read address.
- `mem_rd_data`  in  25: read data, valid exactly 1 cycle after the `mem_rd_en` cycle (synchronous RAM).
- `mem_wr_en`  out  1: write strobe.
- `mem_wr_addr`  out  `ADDR_W`: write address.
- `mem_wr_data`  out  25: permuted slice.
- `done`  out  1: high when idle/complete; low while a run is in progress.

## Operation
- Slice bit index is i = x + 5·y, with x, y ∈ 0..4.
- Forward π: out[x,y] = in[(x+3y) mod 5, x]. Pure combinational wiring on `mem_rd_data`; no arithmetic.
- FSM states: IDLE, RUN, LAST.
  - IDLE: `done`=1, both strobes 0. On `start`=1, go to RUN and clear the read counter.
  - RUN: `mem_rd_en`=1 with `mem_rd_addr`=count; count increments each cycle. When count = `SLICES`-1, go to LAST.
  - LAST: no read; performs the final write; then go to IDLE.
- Write pipeline: one register stage holds the address issued in the previous cycle. In every cycle after a read cycle, `mem_wr_en`=1, `mem_wr_addr`=previous read address, and `mem_wr_data`=π(`mem_rd_data`).
- Read/write of the same address never overlap. The write of address k occurs in the cycle of the read of address k+1.
- `start` while in RUN or LAST is ignored; no restart and no queuing.
- Address counter is `ADDR_W` wide and never wraps within a run; it stops at `SLICES`-1.

## Timing
- Reset values:
  - FSM = IDLE, `done`=1.
  - `mem_rd_en`=0, `mem_wr_en`=0.
  - `mem_rd_addr`=0, `mem_wr_addr`=0, `mem_wr_data`=0.
  - Counter = 0.
- Let E0 be the edge that samples `start`=1 in IDLE.
  - `done` falls in the cycle after E0. The top controller therefore sees `all_done`=0 in its first wait cycle.
  - Reads of addresses 0..`SLICES`-1 occur in cycles 0..`SLICES`-1 after E0.
  - Writes of addresses 0..`SLICES`-1 occur in cycles 1..`SLICES` after E0.
  - `done` returns to 1 in cycle `SLICES`+1 after E0, so it is low for exactly `SLICES`+1 cycles (65 at default).
- `rst` mid-run: at the next edge, all outputs and state return to their reset values. No partial write is issued after the reset edge.
- `rst` and `start` in the same cycle: reset wins; the block stays in IDLE.
- `start` held high continuously: a new run starts on the first cycle back in IDLE. There is no idle gap requirement.

## Configuration
- `PERMUTE_INVERSE_EN` defined: the datapath applies inverse π, out[x,y] = in[y, (2x+3y) mod 5]. This is used on the decoder path.
- Not defined: forward π only.
- FSM, timing and interface are identical in both builds.

## Test plan
- Reset, then idle for 10 cycles → `done`=1, both strobes 0, all addresses 0.
- One-cycle `start`, memory preloaded with slice k = 25'h0000002 for all k → each write carries 25'h0000400 (bit (1,0) moves to (0,2)). `done` is low for exactly 65 cycles, and write addresses run 0..63 in order.
- `PERMUTE_INVERSE_EN` build, same preload → each write carries 25'h0000040 (bit (1,0) moves to (1,1)). A forward run followed by an inverse run restores random preload data bit-exactly.
- `start` pulses at cycles 5 and 30 after E0 → ignored; exactly 64 writes, `done` timing unchanged.
- `rst` asserted at cycle 20 of a run → next cycle `done`=1, strobes 0. A following `start` performs a full 64-slice run from address 0.
- `start` and `rst` asserted together in IDLE → stays IDLE, no read strobe, `done`=1.
